// File: rtl/mcrb_fuse_load_ctrl.sv
// eFuse repair-load sequencer: deserialises the fuse stream into the skew regfile.
// Optional build macro MCRB_FUSE_PARITY_EN adds an even-parity bit per word.
//
// state | meaning
// IDLE  | waiting for ld_start_i
// ARM   | one-cycle fuse-valid strobe, counters cleared
// SHIFT | shift-valid high, one serial bit captured per edge
// WRITE | one-cycle regfile write of the assembled word
// DONE  | one-cycle completion pulse, loaded flag set
module mcrb_fuse_load_ctrl #(
    parameter int NUM_WORDS = 20,
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 5
) (
    input  logic              mc_rb_ef1_sclk_i,
    input  logic              gctl_rclk_orst_i,
    input  logic              ld_start_i,
    input  logic              ld_abort_i,
    input  logic              mc_rb_ef1_sdata_i,
    output logic              mc_rb_fuse_vld_o,
    output logic              mc_rb_ef1_svld_o,
    output logic              skew_wr_en_o,
    output logic [ADDR_W-1:0] skew_wr_addr_o,
    output logic [WORD_W-1:0] skew_wr_data_o,
    output logic              ld_busy_o,
    output logic              ld_done_o,
    output logic              ld_loaded_o,
    output logic              ld_err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int BCW = $clog2(WORD_W + 1);
`ifdef MCRB_FUSE_PARITY_EN
    localparam int LAST_BIT = WORD_W;
`else
    localparam int LAST_BIT = WORD_W - 1;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;
    logic              par_ok;
    logic              wr_fire;

`ifdef MCRB_FUSE_PARITY_EN
    logic              par_q, par_d;
    assign par_ok = (par_q == ^shreg_q);
`else
    assign par_ok = 1'b1;
`endif

    // Abort and parity failure both gate the strobe combinationally in WRITE.
    assign wr_fire = (state_q == S_WRITE) && !ld_abort_i && par_ok;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        addr_d     = addr_q;
        data_d     = data_q;
        loaded_d   = loaded_q;
        err_d      = err_q;
`ifdef MCRB_FUSE_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_start_i && !ld_abort_i) begin
                    state_d  = S_ARM;
                    loaded_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_ARM: begin
                word_cnt_d = '0;
                bit_cnt_d  = '0;
                shreg_d    = '0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                for (int i = 0; i < WORD_W; i++) begin
                    if (bit_cnt_q == BCW'(i)) begin
                        shreg_d[i] = mc_rb_ef1_sdata_i;
                    end
                end
`ifdef MCRB_FUSE_PARITY_EN
                if (bit_cnt_q == BCW'(WORD_W)) begin
                    par_d = mc_rb_ef1_sdata_i;
                end
`endif
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BCW'(LAST_BIT)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    addr_d = word_cnt_q;
                    data_d = shreg_q;
                end
                if (!ld_abort_i && !par_ok) begin
                    err_d = 1'b1;
                end
                if (word_cnt_q == ADDR_W'(NUM_WORDS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                    state_d    = S_SHIFT;
                end
            end
            S_DONE: begin
                if (!ld_abort_i && !err_q) begin
                    loaded_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (ld_abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge mc_rb_ef1_sclk_i or posedge gctl_rclk_orst_i) begin
        if (gctl_rclk_orst_i) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef MCRB_FUSE_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
`ifdef MCRB_FUSE_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign mc_rb_fuse_vld_o = (state_q == S_ARM);
    assign mc_rb_ef1_svld_o = (state_q == S_SHIFT);
    assign skew_wr_en_o     = wr_fire;
    assign skew_wr_addr_o   = wr_fire ? word_cnt_q : addr_q;
    assign skew_wr_data_o   = wr_fire ? shreg_q : data_q;
    assign ld_busy_o        = (state_q != S_IDLE);
    assign ld_done_o        = (state_q == S_DONE) && !ld_abort_i;
    assign ld_loaded_o      = loaded_q;
    assign ld_err_o         = err_q;

endmodule
